// File: rtl/pulse_det.sv
// pulse_det: ADC threshold-crossing detector with period-counter timestamps written to a FIFO.
// Optional falling-edge detection via `define PULSE_DET_POLARITY_EN (adds the polarity input).
module pulse_det #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned NUM_SAMP = 16,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLE_W*NUM_SAMP-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [SAMPLE_W-1:0]          threshold,
  input  logic [PERIOD_W-1:0]          clock_period,
  input  logic                         rst_clock,
  input  logic                         arm,
  input  logic [15:0]                  arm_count,
  input  logic [15:0]                  holdoff,
  input  logic                         abort,
`ifdef PULSE_DET_POLARITY_EN
  input  logic                         polarity,
`endif
  input  logic                         ts_fifo_full,
  output logic                         ts_fifo_write,
  output logic [31:0]                  ts_fifo_data,
  output logic [15:0]                  overflow_count,
  output logic                         busy,
  output logic [7:0]                   state_out
);

  localparam int unsigned WORD_W = SAMPLE_W * NUM_SAMP;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [PERIOD_W-1:0]   cnt;
  logic [7:0]            idx;
  logic signed [SAMPLE_W-1:0] samp [NUM_SAMP];
  logic [NUM_SAMP-1:0]   above_in;
  logic                  s1_valid;
  logic [NUM_SAMP-1:0]   s1_above;
  logic [PERIOD_W-1:0]   s1_cnt;
  logic [7:0]            s1_idx;
  logic                  hist;
  logic [NUM_SAMP-1:0]   rise;
  logic                  det;
  logic [7:0]            fine;
  logic [15:0]           cnt_sat;
  logic [31:0]           event_word;
  logic [15:0]           rem, rem_n, hcnt, hcnt_n, ovf_n;
  logic                  wr_n;

  assign s_axis_tready  = 1'b1;
  assign busy           = (state != IDLE);
  assign state_out      = {6'd0, state};

  // Free-running tick counter; periods of 0 or 1 pin it at zero without wrapping the index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (rst_clock) begin
      cnt <= '0;
      idx <= '0;
    end else if (clock_period <= PERIOD_W'(1)) begin
      cnt <= '0;
    end else if (cnt >= clock_period - PERIOD_W'(1)) begin
      cnt <= '0;
      idx <= idx + 8'd1;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

`ifdef PULSE_DET_POLARITY_EN
  logic signed [SAMPLE_W:0] neg_thr;
  assign neg_thr = -$signed({threshold[SAMPLE_W-1], threshold});
`endif

  always_comb begin
    above_in = '0;
    for (int unsigned k = 0; k < NUM_SAMP; k++) begin
      samp[k] = s_axis_tdata[WORD_W-1-SAMPLE_W*k -: SAMPLE_W];
`ifdef PULSE_DET_POLARITY_EN
      if (polarity)
        above_in[k] = $signed({samp[k][SAMPLE_W-1], samp[k]}) < neg_thr;
      else
        above_in[k] = samp[k] > $signed(threshold);
`else
      above_in[k] = samp[k] > $signed(threshold);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_above <= '0;
      s1_cnt   <= '0;
      s1_idx   <= '0;
      hist     <= 1'b0;
    end else begin
      s1_valid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        s1_above <= above_in;
        s1_cnt   <= cnt;
        s1_idx   <= idx;
      end
      if (s1_valid)
        hist <= s1_above[NUM_SAMP-1];
    end
  end

  // Sample k compares against k-1; sample 0 against the last sample of the previous valid word.
  assign rise = s1_above & ~{s1_above[NUM_SAMP-2:0], hist};
  assign det  = s1_valid & (|rise);

  always_comb begin
    fine = '0;
    for (int unsigned k = 0; k < NUM_SAMP; k++)
      if (rise[NUM_SAMP-1-k])
        fine = 8'(NUM_SAMP-1-k);
  end

  assign cnt_sat    = (s1_cnt > PERIOD_W'(16'hFFFF)) ? 16'hFFFF : s1_cnt[15:0];
  assign event_word = {s1_idx, cnt_sat, fine};

  always_comb begin
    state_n = state;
    rem_n   = rem;
    hcnt_n  = hcnt;
    ovf_n   = overflow_count;
    wr_n    = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_n = ARMED;
            rem_n   = arm_count;
            ovf_n   = '0;
          end
        end
        ARMED: begin
          if (det) begin
            if (!ts_fifo_full) begin
              wr_n = 1'b1;
              if (rem != '0)
                rem_n = rem - 16'd1;
            end else if (overflow_count != '1) begin
              ovf_n = overflow_count + 16'd1;
            end
            if (!ts_fifo_full && rem == 16'd1) begin
              state_n = DONE;
            end else if (holdoff != '0) begin
              state_n = HOLDOFF;
              hcnt_n  = holdoff - 16'd1;
            end
          end
        end
        HOLDOFF: begin
          if (hcnt == '0)
            state_n = ARMED;
          else
            hcnt_n = hcnt - 16'd1;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rem            <= '0;
      hcnt           <= '0;
      overflow_count <= '0;
      ts_fifo_write  <= 1'b0;
      ts_fifo_data   <= '0;
    end else begin
      state          <= state_n;
      rem            <= rem_n;
      hcnt           <= hcnt_n;
      overflow_count <= ovf_n;
      ts_fifo_write  <= wr_n;
      if (wr_n)
        ts_fifo_data <= event_word;
    end
  end

endmodule

// File: tb/tb_pulse_det.sv
// Directed testbench for pulse_det: vector table for single-word detection plus multi-cycle sequences.
// Polarity checks are compiled in when PULSE_DET_POLARITY_EN is defined.
module tb_pulse_det;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [15:0]  threshold;
  logic [23:0]  clock_period;
  logic         rst_clock, arm, abort, ts_fifo_full;
  logic [15:0]  arm_count, holdoff;
  logic         ts_fifo_write;
  logic [31:0]  ts_fifo_data;
  logic [15:0]  overflow_count;
  logic         busy;
  logic [7:0]   state_out;
`ifdef PULSE_DET_POLARITY_EN
  logic         polarity;
`endif

  always #5 clk = ~clk;

  pulse_det #(.SAMPLE_W(16), .NUM_SAMP(16), .PERIOD_W(24)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .threshold(threshold), .clock_period(clock_period), .rst_clock(rst_clock),
    .arm(arm), .arm_count(arm_count), .holdoff(holdoff), .abort(abort),
`ifdef PULSE_DET_POLARITY_EN
    .polarity(polarity),
`endif
    .ts_fifo_full(ts_fifo_full), .ts_fifo_write(ts_fifo_write), .ts_fifo_data(ts_fifo_data),
    .overflow_count(overflow_count), .busy(busy), .state_out(state_out)
  );

  int tests = 0;
  int fails = 0;

  // Reference period counter / index, used to predict timestamps.
  logic [23:0] m_cnt;
  logic [7:0]  m_idx;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= '0; m_idx <= '0;
    end else if (rst_clock) begin
      m_cnt <= '0; m_idx <= '0;
    end else if (clock_period <= 24'd1) begin
      m_cnt <= '0;
    end else if (m_cnt >= clock_period - 24'd1) begin
      m_cnt <= '0; m_idx <= m_idx + 8'd1;
    end else begin
      m_cnt <= m_cnt + 24'd1;
    end
  end

  logic [31:0] wq[$];
  always @(negedge clk)
    if (ts_fifo_write) wq.push_back(ts_fifo_data);

  function automatic logic [23:0] stamp();
    return {m_idx, (m_cnt > 24'h00FFFF) ? 16'hFFFF : m_cnt[15:0]};
  endfunction

  function automatic logic [255:0] put(input logic [255:0] w, input int k, input logic [15:0] v);
    logic [255:0] r;
    r = w;
    r[255-16*k -: 16] = v;
    return r;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] stamp_q;
  task automatic send(input logic [255:0] w);
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    stamp_q       = stamp();
    cyc();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic arm_now(input logic [15:0] cnt, input logic [15:0] hold);
    arm_count = cnt;
    holdoff   = hold;
    arm       = 1'b1;
    cyc();
    arm       = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [15:0]  thr;
    logic [255:0] word;
    logic         hit;
    logic [7:0]   fine;
  } vec_t;

  vec_t        tbl[10];
  logic [23:0] stamps[7];
  logic [255:0] w3;

  initial begin
    tbl[0] = '{"s5_mid",      16'h1000, put(fill(16'h0000), 5, 16'h4000),  1'b1, 8'd5};
    tbl[1] = '{"s0_first",    16'h1000, put(fill(16'h0000), 0, 16'h4000),  1'b1, 8'd0};
    tbl[2] = '{"equal_thr",   16'h1000, put(fill(16'h0000), 15, 16'h1000), 1'b0, 8'd0};
    tbl[3] = '{"s15_last",    16'h1000, put(fill(16'h0000), 15, 16'h1001), 1'b1, 8'd15};
    tbl[4] = '{"lowest_wins", 16'h1000, put(put(fill(16'h0000), 3, 16'h2000), 9, 16'h2000), 1'b1, 8'd3};
    tbl[5] = '{"plateau",     16'h1000, put(put(put(put(put(fill(16'h0000), 2, 16'h2000), 3, 16'h2000), 4, 16'h2000), 5, 16'h2000), 6, 16'h2000), 1'b1, 8'd2};
    tbl[6] = '{"neg_thr",     16'hFF00, put(fill(16'h8000), 7, 16'h0000),  1'b1, 8'd7};
    tbl[7] = '{"neg_sample",  16'h1000, put(fill(16'h0000), 4, 16'hC000),  1'b0, 8'd0};
    tbl[8] = '{"max_thr",     16'h7FFF, fill(16'h7FFF),                    1'b0, 8'd0};
    tbl[9] = '{"min_thr",     16'h8000, put(fill(16'h8000), 1, 16'h8001),  1'b1, 8'd1};

    rst = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    threshold = 16'h1000; clock_period = 24'd10;
    rst_clock = 1'b0; arm = 1'b0; abort = 1'b0; ts_fifo_full = 1'b0;
    arm_count = '0; holdoff = '0;
`ifdef PULSE_DET_POLARITY_EN
    polarity = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    check("rst_write",  32'(ts_fifo_write), 32'd0);
    check("rst_data",   ts_fifo_data, 32'd0);
    check("rst_ovf",    32'(overflow_count), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_state",  32'(state_out), 32'd0);
    rst = 1'b1;
    cyc();

    // Single-word vectors: unlimited capture, no holdoff, history cleared by an all-minimum word.
    rst_clock = 1'b1;
    arm_now(16'd0, 16'd0);
    rst_clock = 1'b0;
    check("armed_state", 32'(state_out), 32'd1);
    for (int i = 0; i < 10; i++) begin
      threshold = tbl[i].thr;
      send(fill(16'h8000));
      send(tbl[i].word);
      cyc();
      check({tbl[i].name, "_write"}, 32'(ts_fifo_write), 32'(tbl[i].hit));
      if (tbl[i].hit)
        check({tbl[i].name, "_data"}, ts_fifo_data, {stamp_q, tbl[i].fine});
    end

    // Basic capture: arm_count=1, word accepted at counter 3 / index 0.
    do_abort();
    threshold = 16'h1000; clock_period = 24'd10; rst_clock = 1'b1;
    arm_now(16'd1, 16'd0);
    rst_clock = 1'b0;
    cyc(); cyc(); cyc();
    send(put(fill(16'h0000), 5, 16'h4000));
    check("basic_no_early_write", 32'(ts_fifo_write), 32'd0);
    cyc();
    check("basic_write", 32'(ts_fifo_write), 32'd1);
    check("basic_data",  ts_fifo_data, 32'h00000305);
    check("basic_done",  32'(state_out), 32'd3);
    cyc();
    check("basic_write_one_cycle", 32'(ts_fifo_write), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);

    // Crossing split across words with a tvalid gap.
    arm_now(16'd0, 16'd0);
    wq.delete();
    send(put(fill(16'h0000), 15, 16'h4000));
    cyc(); cyc();
    send(put(fill(16'h0000), 0, 16'h4000));
    cyc(); cyc(); cyc();
    check("split_count", 32'(wq.size()), 32'd1);
    check("split_fine", (wq.size() > 0) ? {24'd0, wq[0][7:0]} : 32'hDEADBEEF, 32'd15);

    // Holdoff of 4 cycles with a crossing in every word.
    do_abort();
    arm_now(16'd0, 16'd4);
    wq.delete();
    w3 = put(fill(16'h0000), 3, 16'h4000);
    for (int i = 0; i < 7; i++) begin
      s_axis_tdata  = w3;
      s_axis_tvalid = 1'b1;
      stamps[i]     = stamp();
      cyc();
    end
    s_axis_tvalid = 1'b0;
    repeat (6) cyc();
    check("holdoff_count", 32'(wq.size()), 32'd2);
    check("holdoff_first",  (wq.size() > 0) ? wq[0] : 32'hDEADBEEF, {stamps[0], 8'd3});
    check("holdoff_second", (wq.size() > 1) ? wq[1] : 32'hDEADBEEF, {stamps[5], 8'd3});

    // FIFO full: drops counted, remaining untouched, cleared by a fresh arm.
    do_abort();
    arm_now(16'd2, 16'd0);
    ts_fifo_full = 1'b1;
    wq.delete();
    send(w3); send(w3); send(w3);
    cyc(); cyc();
    check("full_no_writes", 32'(wq.size()), 32'd0);
    check("full_ovf",       32'(overflow_count), 32'd3);
    check("full_still_armed", 32'(state_out), 32'd1);
    ts_fifo_full = 1'b0;
    send(w3);
    cyc();
    check("full_after_write", 32'(ts_fifo_write), 32'd1);
    check("full_rem_kept", 32'(state_out), 32'd1);
    send(w3);
    cyc();
    check("full_second_done", 32'(state_out), 32'd3);
    cyc();
    check("full_ovf_held", 32'(overflow_count), 32'd3);
    arm_now(16'd1, 16'd0);
    check("rearm_ovf_clear", 32'(overflow_count), 32'd0);

    // arm while busy must not reload arm_count.
    arm_now(16'd0, 16'd0);
    send(w3);
    cyc();
    check("arm_busy_ignored", 32'(state_out), 32'd3);
    cyc();

    // Abort in the same cycle as a detection.
    arm_now(16'd0, 16'd0);
    wq.delete();
    send(w3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_no_write", 32'(ts_fifo_write), 32'd0);
    check("abort_idle", 32'(state_out), 32'd0);
    cyc();
    check("abort_queue", 32'(wq.size()), 32'd0);

    // clock_period=1 holds the counter and index at zero.
    clock_period = 24'd1;
    rst_clock = 1'b1;
    arm_now(16'd0, 16'd0);
    rst_clock = 1'b0;
    repeat (5) cyc();
    send(put(fill(16'h0000), 9, 16'h4000));
    cyc();
    check("period1_data", ts_fifo_data, 32'h00000009);
    clock_period = 24'd10;

`ifdef PULSE_DET_POLARITY_EN
    threshold = 16'h1000;
    polarity = 1'b1;
    send(put(fill(16'h0000), 2, 16'hC000));
    cyc();
    check("pol_fall_write", 32'(ts_fifo_write), 32'd1);
    check("pol_fall_fine", {24'd0, ts_fifo_data[7:0]}, 32'd2);
    polarity = 1'b0;
    send(put(fill(16'h0000), 2, 16'hC000));
    cyc();
    check("pol_rise_none", 32'(ts_fifo_write), 32'd0);
`endif

    // Asynchronous reset in the middle of HOLDOFF.
    do_abort();
    arm_now(16'd0, 16'd8);
    send(w3);
    cyc();
    check("pre_rst_holdoff", 32'(state_out), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    check("arst_write", 32'(ts_fifo_write), 32'd0);
    check("arst_data",  ts_fifo_data, 32'd0);
    check("arst_ovf",   32'(overflow_count), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_state", 32'(state_out), 32'd0);
    check("arst_tready", 32'(s_axis_tready), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
